// File: rtl/program_loader.sv
// program_loader
//   Writer side of the program-memory interface. Parses a framed byte stream
//   (MAGIC, COUNT, COUNT x {hi, lo}, CHECK), assembles 16-bit instruction
//   words into a DEPTH x 16 RAM and serves the core's combinational fetch.
//   The core is held in reset until a frame loads with a matching checksum.
// Ports
//   clock, reset        system clock (rising edge), synchronous active-high reset
//   rx_data/rx_valid    incoming byte stream
//   rx_ready            byte accepted on a clock edge where rx_valid && rx_ready
//   pc_addr/instr_out   core fetch address / RAM[pc_addr] (combinational)
//   cpu_reset           holds the core in reset while high
//   load_done           one-cycle pulse after a frame passes its checksum
//   load_error          sticky error flag, cleared by the next MAGIC byte
//   words_loaded        words written by the current/last frame
module program_loader #(
    parameter int          ADDR_W = 5,
    parameter int          DEPTH  = 32,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [15:0]       instr_out,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [5:0]        words_loaded
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    // Errors are detected in COUNT/CHECK and leave straight for IDLE in the
    // same cycle, so there is no resident error state.
    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHECK, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         csum;
    logic [7:0]         hi_byte;
    logic [5:0]         count;
    logic [15:0]        mem [DEPTH];

    logic accept;

    assign rx_ready  = (state != DONE);
    assign accept    = rx_valid && rx_ready;
    assign instr_out = mem[pc_addr];

    // RAM is never cleared; reset only blocks a write on its own edge.
    // Fetch reads see the old word on a same-address write cycle.
    always_ff @(posedge clock) begin
        if (!reset && state == LO && accept)
            mem[addr] <= {hi_byte, rx_data};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            addr         <= '0;
            csum         <= '0;
            hi_byte      <= '0;
            count        <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && rx_data == MAGIC) begin
                        state        <= COUNT;
                        cpu_reset    <= 1'b1;
                        load_error   <= 1'b0;
                        words_loaded <= '0;
                        addr         <= '0;
                        csum         <= '0;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        if (rx_data == 8'd0 || rx_data > DEPTH_B) begin
                            load_error <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            count <= rx_data[5:0];
                            csum  <= csum ^ rx_data;
                            state <= HI;
                        end
                    end
                end
                HI: begin
                    if (accept) begin
                        hi_byte <= rx_data;
                        csum    <= csum ^ rx_data;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (accept) begin
                        // addr never passes DEPTH-1 because count <= DEPTH
                        addr         <= addr + 1'b1;
                        words_loaded <= words_loaded + 6'd1;
                        csum         <= csum ^ rx_data;
                        state        <= (words_loaded + 6'd1 == count) ? CHECK : HI;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            load_done <= 1'b1;   // high for the DONE cycle
                            state     <= DONE;
                        end else begin
                            load_error <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                DONE: begin
                    cpu_reset <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes the expected frame
// outcome (done/error + words_loaded) into a queue; a monitor pops and
// compares whenever the DUT pulses load_done or raises load_error.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [4:0]  pc_addr;
    logic [15:0] instr_out;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [5:0]  words_loaded;

    program_loader dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .pc_addr(pc_addr), .instr_out(instr_out),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         is_err;
        logic [5:0] words;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] fr[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       prev_err = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: frame outcomes as seen on the DUT outputs.
    always @(negedge clock) begin
        if (!reset) begin
            if (load_done || (load_error && !prev_err)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_event: done=%0b err=%0b words=%0d", load_done, load_error, words_loaded);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_kind_is_err", {31'd0, load_error}, {31'd0, e.is_err});
                    check("event_words", {26'd0, words_loaded}, {26'd0, e.words});
                    if (load_done) check("rx_ready_in_done", {31'd0, rx_ready}, 32'd0);
                end
            end
        end
        prev_err = load_error;
    end

    task automatic send(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            rx_valid = 1'b0;
            rx_data  = 8'hA5;          // junk on an invalid bus must be ignored
            n = $urandom_range(0, 3);
            repeat (n) begin @(posedge clock); #1; end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 20) begin @(posedge clock); #1; n++; end
        if (!rx_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL rx_ready_timeout: got 0, expected 1");
        end
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        foreach (fr[i]) send(fr[i], gaps);
    endtask

    // Bounded wait for the outcome; anything still queued is a miss.
    task automatic settle();
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("event_pending", exp_q.size(), 32'd0);
    endtask

    task automatic rd(input logic [4:0] a, input logic [15:0] exp, input string name);
        pc_addr = a;
        #1;
        check(name, {16'd0, instr_out}, {16'd0, exp});
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc_addr  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_error", {31'd0, load_error}, 32'd0);
        check("rst_words", {26'd0, words_loaded}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // 1: good two-word frame, check = 02^12^34^AB^CD = 42
        fr = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        exp_q.push_back('{1'b0, 6'd2});
        send_frame(1'b0);
        settle();
        check("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("t1_words", {26'd0, words_loaded}, 32'd2);
        check("t1_err", {31'd0, load_error}, 32'd0);
        rd(5'd0, 16'h1234, "t1_ram0");
        rd(5'd1, 16'hABCD, "t1_ram1");

        // 2: bad checksum (good would be 02^11^22^33^44 = 46)
        fr = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h47};
        exp_q.push_back('{1'b1, 6'd2});
        send_frame(1'b0);
        settle();
        check("t2_err", {31'd0, load_error}, 32'd1);
        check("t2_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        rd(5'd0, 16'h1122, "t2_ram0");
        rd(5'd1, 16'h3344, "t2_ram1");

        // 3: COUNT out of range at both ends
        fr = '{8'hA5, 8'h00};
        exp_q.push_back('{1'b1, 6'd0});
        send_frame(1'b0);
        settle();
        check("t3a_words", {26'd0, words_loaded}, 32'd0);
        rd(5'd0, 16'h1122, "t3a_ram0");
        fr = '{8'hA5, 8'h21};
        exp_q.push_back('{1'b1, 6'd0});
        send_frame(1'b0);
        settle();
        check("t3b_words", {26'd0, words_loaded}, 32'd0);
        check("t3b_err", {31'd0, load_error}, 32'd1);
        rd(5'd1, 16'h3344, "t3b_ram1");

        // 4: garbage then full 32-word frame; word i = {i, ~i}.
        // XOR of 0..31 is 0 and of ~0..~31 is 0, so check = COUNT = 20.
        fr = '{8'h00, 8'hFF, 8'hA5, 8'h20};
        for (int i = 0; i < 32; i++) begin
            fr.push_back(8'(i));
            fr.push_back(~8'(i));
        end
        fr.push_back(8'h20);
        exp_q.push_back('{1'b0, 6'd32});
        send_frame(1'b0);
        settle();
        check("t4_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("t4_words", {26'd0, words_loaded}, 32'd32);
        rd(5'd31, 16'h1FE0, "t4_ram31");
        rd(5'd0, 16'h00FF, "t4_ram0");
        rd(5'd16, 16'h10EF, "t4_ram16");

        // 5: reset after the 3rd data byte; word 0 already written
        fr = '{8'hA5, 8'h02, 8'h56, 8'h78, 8'h9A};
        send_frame(1'b0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("t5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("t5_words", {26'd0, words_loaded}, 32'd0);
        check("t5_err", {31'd0, load_error}, 32'd0);
        rd(5'd0, 16'h5678, "t5_ram0_kept");
        rd(5'd1, 16'h01FE, "t5_ram1_untouched");
        @(posedge clock); #1;
        reset = 1'b0;
        // reload: 02^56^78^9A^BC = 0A
        fr = '{8'hA5, 8'h02, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h0A};
        exp_q.push_back('{1'b0, 6'd2});
        send_frame(1'b0);
        settle();
        check("t5r_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        rd(5'd0, 16'h5678, "t5r_ram0");
        rd(5'd1, 16'h9ABC, "t5r_ram1");

        // 6: frame 1 again with random rx_valid gaps
        fr = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        exp_q.push_back('{1'b0, 6'd2});
        send_frame(1'b1);
        settle();
        check("t6_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("t6_words", {26'd0, words_loaded}, 32'd2);
        rd(5'd0, 16'h1234, "t6_ram0");
        rd(5'd1, 16'hABCD, "t6_ram1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
